// File: rtl/serial_parallel_rx_pkg.sv
// Shared PHY lane definitions: comma character, lane alignment states and
// the default comma count required for lock.
package serial_parallel_rx_pkg;

    localparam logic [7:0]  COMMA_BC           = 8'hBC;
    localparam int unsigned SYNC_COUNT_DEFAULT = 4;

    // Also used by the lane TX serializer's idle logic.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_e;

endpackage : serial_parallel_rx_pkg

// File: rtl/serial_parallel_rx.sv
// Per-lane RX deserializer: bit-slip comma search, comma-count lock, then one
// registered byte plus valid flag presented per byte period.
module serial_parallel_rx
    import serial_parallel_rx_pkg::*;
#(
    parameter logic [7:0]  COMMA      = COMMA_BC,
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_par,
    output logic       valid_par,
    output logic       active
);

    localparam logic [3:0] SYNC_CNT = 4'(SYNC_COUNT);

    lane_state_e state_q;
    logic [7:0]  sr_q;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  comma_cnt_q;
    logic [7:0]  data_par_q;
    logic        valid_par_q;
    logic        active_q;

    logic [7:0]  cand;
    logic        cand_is_comma;
    logic        boundary;

    // cand is the byte completed by the bit sampled at this edge.
    always_comb begin
        cand          = {sr_q[6:0], data_in};
        cand_is_comma = (cand == COMMA);
        boundary      = (bit_cnt_q == 3'd7);
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_par_q  <= '0;
            valid_par_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            sr_q      <= cand;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            case (state_q)
                SEARCH: begin
                    // Any bit position may start a byte; a hit re-phases the counter.
                    if (cand_is_comma) begin
                        bit_cnt_q   <= '0;
                        comma_cnt_q <= 4'd1;
                        if (SYNC_CNT == 4'd1) begin
                            state_q  <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (cand_is_comma) begin
                            comma_cnt_q <= comma_cnt_q + 4'd1;
                            if (comma_cnt_q + 4'd1 == SYNC_CNT) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            comma_cnt_q <= '0;
                            state_q     <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary) begin
                        data_par_q  <= cand;
                        valid_par_q <= !cand_is_comma;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_par  = data_par_q;
    assign valid_par = valid_par_q;
    assign active    = active_q;

endmodule : serial_parallel_rx

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: lock, bit-slip, broken preamble,
// idle commas, async reset mid-byte, and single-comma lock.
module tb_serial_parallel_rx;

    logic       clk_8f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_par0, data_par1;
    logic       valid_par0, valid_par1;
    logic       active0, active1;

    int unsigned checks;
    int unsigned failures;

    serial_parallel_rx #(.COMMA(8'hBC), .SYNC_COUNT(4)) dut0 (
        .clk_8f    (clk_8f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_par  (data_par0),
        .valid_par (valid_par0),
        .active    (active0)
    );

    serial_parallel_rx #(.COMMA(8'hBC), .SYNC_COUNT(1)) dut1 (
        .clk_8f    (clk_8f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_par  (data_par1),
        .valid_par (valid_par1),
        .active    (active1)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit driven at negedge, sampled at the following posedge; returns 1 time unit after it.
    task automatic send_bit(input logic b);
        @(negedge clk_8f);
        data_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic send_range(input logic [7:0] b, input int unsigned first, input int unsigned count);
        for (int unsigned i = 0; i < count; i++) begin
            send_bit(b[7 - (first + i)]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_range(b, 0, 8);
    endtask

    // Previous outputs must hold through bits 0..6; the new byte appears after bit 7.
    task automatic send_byte_hold(input string tag, input logic [7:0] b,
                                  input logic [7:0] prev_d, input logic prev_v);
        for (int unsigned i = 0; i < 7; i++) begin
            send_bit(b[7 - i]);
            chk({tag, "_hold_d"}, {24'd0, data_par0}, {24'd0, prev_d});
            chk({tag, "_hold_v"}, {31'd0, valid_par0}, {31'd0, prev_v});
        end
        send_bit(b[0]);
        chk({tag, "_d"}, {24'd0, data_par0}, {24'd0, b});
        chk({tag, "_v"}, {31'd0, valid_par0}, {31'd0, (b != 8'hBC)});
    endtask

    task automatic do_reset;
        #2;
        reset_L = 1'b0;
        data_in = 1'b0;
        #1;
        chk("rst_data", {24'd0, data_par0}, 32'h0);
        chk("rst_valid", {31'd0, valid_par0}, 32'h0);
        chk("rst_active", {31'd0, active0}, 32'h0);
        repeat (3) @(posedge clk_8f);
        @(negedge clk_8f);
        reset_L = 1'b1;
    endtask

    task automatic lock4(input string tag);
        for (int unsigned k = 0; k < 3; k++) begin
            send_byte(8'hBC);
            chk({tag, "_pre_active"}, {31'd0, active0}, 32'h0);
        end
        send_range(8'hBC, 0, 7);
        chk({tag, "_act_before_last"}, {31'd0, active0}, 32'h0);
        send_bit(1'b0);
        chk({tag, "_act_rise"}, {31'd0, active0}, 32'h1);
        chk({tag, "_lock_d"}, {24'd0, data_par0}, 32'h0);
        chk({tag, "_lock_v"}, {31'd0, valid_par0}, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_L  = 1'b0;
        data_in  = 1'b0;

        // Clean lock
        do_reset();
        lock4("clean");
        send_byte_hold("clean_5a", 8'h5A, 8'h00, 1'b0);
        send_byte_hold("clean_81", 8'h81, 8'h5A, 1'b1);

        // Offset alignment: three stray bits shift the comma phase
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        lock4("offset");
        send_byte_hold("offset_ff", 8'hFF, 8'h00, 1'b0);

        // Idle commas while active
        send_byte_hold("idle_12", 8'h12, 8'hFF, 1'b1);
        send_byte_hold("idle_bc", 8'hBC, 8'h12, 1'b1);
        send_byte_hold("idle_34", 8'h34, 8'hBC, 1'b0);

        // Async reset three bits into a data byte
        send_range(8'h77, 0, 3);
        chk("mid_pre_d", {24'd0, data_par0}, 32'h34);
        chk("mid_pre_act", {31'd0, active0}, 32'h1);
        do_reset();
        lock4("relock");
        send_byte_hold("relock_a5", 8'hA5, 8'h00, 1'b0);

        // Broken preamble: the zero byte forces a fresh search
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h00);
        chk("broken_after_00", {31'd0, active0}, 32'h0);
        lock4("broken");
        send_byte_hold("broken_c3", 8'hC3, 8'h00, 1'b0);

        // SYNC_COUNT = 1 instance locks on the first comma
        do_reset();
        send_range(8'hBC, 0, 7);
        chk("sc1_before", {31'd0, active1}, 32'h0);
        send_bit(1'b0);
        chk("sc1_active", {31'd0, active1}, 32'h1);
        chk("sc1_valid0", {31'd0, valid_par1}, 32'h0);
        send_byte(8'h3C);
        chk("sc1_d", {24'd0, data_par1}, 32'h3C);
        chk("sc1_v", {31'd0, valid_par1}, 32'h1);
        chk("sc1_dut0_idle", {31'd0, active0}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_parallel_rx
